// File: rtl/mpt_mem_arbiter.sv
// Round-robin arbiter sharing one memory master port among the MPT walking stages.
// Requester IDs are queued in grant order so each response returns to its issuer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | pick next requester from rr_ptr; forward it, grant if master grants
// ST_LOCKED | master stalled a request; hold lock_id's request until granted
module mpt_mem_arbiter #(
  parameter int NUM_REQUESTERS    = 3,
  parameter int MEMORY_DATA_WIDTH = 64,
  parameter int MEMORY_ADDR_WIDTH = 64,
  parameter int MAX_OUTSTANDING   = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic [NUM_REQUESTERS-1:0]                      slave_mem_req,
  output logic [NUM_REQUESTERS-1:0]                      slave_mem_gnt,
  input  logic [NUM_REQUESTERS*MEMORY_ADDR_WIDTH-1:0]    slave_mem_addr,
  input  logic [NUM_REQUESTERS*MEMORY_DATA_WIDTH-1:0]    slave_mem_wdata,
  input  logic [NUM_REQUESTERS-1:0]                      slave_mem_we,
  input  logic [NUM_REQUESTERS*(MEMORY_DATA_WIDTH/8)-1:0] slave_mem_be,
  output logic [NUM_REQUESTERS-1:0]                      slave_mem_valid,
  output logic [MEMORY_DATA_WIDTH-1:0]                   slave_mem_rdata,
  output logic [NUM_REQUESTERS-1:0]                      slave_mem_error,
  output logic                                           memory_master_mem_req,
  input  logic                                           memory_master_mem_gnt,
  output logic [MEMORY_ADDR_WIDTH-1:0]                   memory_master_mem_addr,
  output logic [MEMORY_DATA_WIDTH-1:0]                   memory_master_mem_wdata,
  output logic                                           memory_master_mem_we,
  output logic [MEMORY_DATA_WIDTH/8-1:0]                 memory_master_mem_be,
  input  logic                                           memory_master_mem_valid,
  input  logic [MEMORY_DATA_WIDTH-1:0]                   memory_master_mem_rdata,
  input  logic                                           memory_master_mem_error,
  output logic                                           unexpected_rsp_o
);

  localparam int BW   = MEMORY_DATA_WIDTH / 8;
  localparam int IDW  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int PW   = $clog2(MAX_OUTSTANDING);
  localparam int CNTW = PW + 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;
  logic [IDW-1:0]  sel, cur_id, head_id;
  logic            found, cur_req, grant;

  logic [IDW-1:0]  id_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] fifo_cnt;
  logic            fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (fifo_cnt == CNTW'(MAX_OUTSTANDING));
  assign fifo_empty = (fifo_cnt == '0);

  // First requesting port at or above rr_ptr, wrapping around.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!found && slave_mem_req[(int'(rr_ptr_q) + i) % NUM_REQUESTERS]) begin
        found = 1'b1;
        sel   = IDW'((int'(rr_ptr_q) + i) % NUM_REQUESTERS);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    cur_id    = sel;
    cur_req   = 1'b0;
    case (state_q)
      ST_IDLE:   cur_req = found && !fifo_full;
      ST_LOCKED: begin
        cur_id  = lock_id_q;
        cur_req = 1'b1;
      end
      default: ;
    endcase
    // Grants are combinational from the master, so reset must mask them directly.
    cur_req = cur_req && rst_ni;
    grant   = cur_req && memory_master_mem_gnt;
    if (grant) begin
      rr_ptr_d = (cur_id == IDW'(NUM_REQUESTERS - 1)) ? '0 : cur_id + 1'b1;
      state_d  = ST_IDLE;
    end else if (cur_req && (state_q == ST_IDLE)) begin
      lock_id_d = sel;
      state_d   = ST_LOCKED;
    end
    memory_master_mem_req = cur_req;
    slave_mem_gnt         = '0;
    if (grant) slave_mem_gnt[cur_id] = 1'b1;
  end

  assign memory_master_mem_addr  = slave_mem_addr[int'(cur_id)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  assign memory_master_mem_wdata = slave_mem_wdata[int'(cur_id)*MEMORY_DATA_WIDTH +: MEMORY_DATA_WIDTH];
  assign memory_master_mem_we    = slave_mem_we[cur_id];
  assign memory_master_mem_be    = slave_mem_be[int'(cur_id)*BW +: BW];

  assign push    = grant;
  assign pop     = memory_master_mem_valid && !fifo_empty;
  assign head_id = id_fifo[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      unexpected_rsp_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (memory_master_mem_valid && fifo_empty) unexpected_rsp_o <= 1'b1;
    end
  end

  // ID storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) id_fifo[wr_ptr] <= cur_id;
  end

  always_comb begin
    slave_mem_valid = '0;
    slave_mem_error = '0;
    if (pop) begin
      slave_mem_valid[head_id] = 1'b1;
      slave_mem_error[head_id] = memory_master_mem_error;
    end
  end

  assign slave_mem_rdata = memory_master_mem_rdata;

endmodule

// File: tb/tb_mpt_mem_arbiter.sv
// Scoreboard bench for mpt_mem_arbiter: directed stimulus queues expected grants and
// responses; a negedge monitor pops and compares whenever the DUT grants or responds.
module tb_mpt_mem_arbiter;
  localparam int NR = 3;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int MO = 4;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    gnt_s, vld_s, err_s;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    we;
  logic [NR*BW-1:0] be;
  logic [DW-1:0]    rdata_s;
  logic             m_req, m_we, unexp;
  logic             m_gnt = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [BW-1:0]    m_be;
  logic [DW-1:0]    m_rdata = '0;

  mpt_mem_arbiter #(
    .NUM_REQUESTERS(NR), .MEMORY_DATA_WIDTH(DW),
    .MEMORY_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slave_mem_req(req), .slave_mem_gnt(gnt_s),
    .slave_mem_addr(addr), .slave_mem_wdata(wdata),
    .slave_mem_we(we), .slave_mem_be(be),
    .slave_mem_valid(vld_s), .slave_mem_rdata(rdata_s), .slave_mem_error(err_s),
    .memory_master_mem_req(m_req), .memory_master_mem_gnt(m_gnt),
    .memory_master_mem_addr(m_addr), .memory_master_mem_wdata(m_wdata),
    .memory_master_mem_we(m_we), .memory_master_mem_be(m_be),
    .memory_master_mem_valid(m_valid), .memory_master_mem_rdata(m_rdata),
    .memory_master_mem_error(m_err),
    .unexpected_rsp_o(unexp)
  );

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic          we;
  } gnt_t;
  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endfunction

  // Hand-built table of requester attributes.
  function automatic logic [AW-1:0] base_addr(int r);
    case (r)
      0:       return 64'h2000;
      1:       return 64'h1000;
      default: return 64'h3000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_g(int id);
    gnt_t g;
    g.id    = id;
    g.addr  = base_addr(id);
    g.wdata = 64'hA0 + 64'(id);
    g.be    = 8'h11 * 8'(id + 1);
    g.we    = (id == 1);
    exp_gnt.push_back(g);
  endtask

  task automatic exp_r(int id, logic [DW-1:0] rd, logic e);
    rsp_t r;
    r.id    = id;
    r.rdata = rd;
    r.err   = e;
    exp_rsp.push_back(r);
    m_valid = 1'b1;
    m_rdata = rd;
    m_err   = e;
  endtask

  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    if (gnt_s != '0) begin
      if (exp_gnt.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_gnt actual=%0h required=0", gnt_s);
      end else begin
        g = exp_gnt.pop_front();
        chk("gnt_vec", 64'(gnt_s), 64'(1) << g.id);
        chk("gnt_mreq", 64'(m_req), 64'd1);
        chk("gnt_addr", m_addr, g.addr);
        chk("gnt_wdata", m_wdata, g.wdata);
        chk("gnt_be", 64'(m_be), 64'(g.be));
        chk("gnt_we", 64'(m_we), 64'(g.we));
      end
    end
    if (vld_s != '0) begin
      if (exp_rsp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_valid actual=%0h required=0", vld_s);
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp_vec", 64'(vld_s), 64'(1) << r.id);
        chk("rsp_rdata", rdata_s, r.rdata);
        chk("rsp_err", 64'(err_s), 64'(r.err) << r.id);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int ord2[6];
    int ord4[4];
    ord2 = '{2, 0, 1, 2, 0, 1};
    ord4 = '{1, 0, 1, 0};
    for (int r = 0; r < NR; r++) begin
      addr[r*AW +: AW]  = base_addr(r);
      wdata[r*DW +: DW] = 64'hA0 + 64'(r);
      be[r*BW +: BW]    = 8'h11 * 8'(r + 1);
    end
    we = 3'b010;

    // Reset: requests and master grant active, yet nothing may be granted.
    req   = 3'b111;
    m_gnt = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_gnt", 64'(gnt_s), 64'd0);
    chk("rst_mreq", 64'(m_req), 64'd0);
    chk("rst_valid", 64'(vld_s), 64'd0);
    chk("rst_unexp", 64'(unexp), 64'd0);
    step();
    req   = '0;
    m_gnt = 1'b0;
    rst_n = 1'b1;
    step();

    // Single zero-wait request from requester 1, response next cycle.
    req   = 3'b010;
    m_gnt = 1'b1;
    exp_g(1);
    @(negedge clk);
    chk("single_mreq", 64'(m_req), 64'd1);
    step();
    req   = '0;
    m_gnt = 1'b0;
    exp_r(1, 64'hDEAD, 1'b0);
    step();
    m_valid = 1'b0;
    @(negedge clk);
    chk("single_idle_valid", 64'(vld_s), 64'd0);
    step();

    // Round robin from rr_ptr=2 with responses streaming one cycle behind.
    for (int k = 0; k < 6; k++) begin
      req   = 3'b111;
      m_gnt = 1'b1;
      exp_g(ord2[k]);
      if (k > 0) exp_r(ord2[k-1], 64'h100 + 64'(k - 1), 1'b0);
      else m_valid = 1'b0;
      step();
    end
    req   = '0;
    m_gnt = 1'b0;
    exp_r(ord2[5], 64'h105, 1'b0);
    step();
    m_valid = 1'b0;
    step();

    // Lock under backpressure: requester 2 held while requester 0 rises.
    req = 3'b100;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req = 3'b101;
      @(negedge clk);
      chk("lock_addr", m_addr, 64'h3000);
      chk("lock_mreq", 64'(m_req), 64'd1);
      chk("lock_nognt", 64'(gnt_s), 64'd0);
      step();
    end
    m_gnt = 1'b1;
    exp_g(2);
    step();
    req = 3'b001;
    exp_g(0);
    step();
    req   = '0;
    m_gnt = 1'b0;
    exp_r(2, 64'h200, 1'b0);
    step();
    exp_r(0, 64'h201, 1'b1);
    step();
    m_valid = 1'b0;
    step();

    // Fill the ID FIFO with no responses, then stall, pop one, resume.
    req   = 3'b011;
    m_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g(ord4[k]);
      step();
    end
    @(negedge clk);
    chk("full_mreq", 64'(m_req), 64'd0);
    chk("full_gnt", 64'(gnt_s), 64'd0);
    step();
    exp_r(1, 64'h300, 1'b1);
    @(negedge clk);
    chk("full_pop_mreq", 64'(m_req), 64'd0);
    chk("full_pop_gnt", 64'(gnt_s), 64'd0);
    step();
    m_valid = 1'b0;
    exp_g(1);
    step();
    req   = '0;
    m_gnt = 1'b0;
    exp_r(0, 64'h301, 1'b0);
    step();
    exp_r(1, 64'h302, 1'b1);
    step();
    exp_r(0, 64'h303, 1'b0);
    step();
    exp_r(1, 64'h304, 1'b0);
    step();
    m_valid = 1'b0;
    step();

    // Simultaneous push and pop at count 2, then drain exactly two.
    req   = 3'b101;
    m_gnt = 1'b1;
    exp_g(2);
    step();
    exp_g(0);
    step();
    exp_g(2);
    exp_r(2, 64'h400, 1'b0);
    step();
    req   = '0;
    m_gnt = 1'b0;
    exp_r(0, 64'h401, 1'b0);
    step();
    exp_r(2, 64'h402, 1'b1);
    step();
    m_valid = 1'b0;
    @(negedge clk);
    chk("drained_unexp", 64'(unexp), 64'd0);
    step();

    // Spurious response with an empty FIFO.
    m_valid = 1'b1;
    m_rdata = 64'h999;
    m_err   = 1'b1;
    @(negedge clk);
    chk("spur_valid", 64'(vld_s), 64'd0);
    chk("spur_err", 64'(err_s), 64'd0);
    step();
    m_valid = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    chk("spur_unexp", 64'(unexp), 64'd1);
    step();

    // Reset with two IDs in flight: flag, FIFO and rr_ptr must all clear.
    req   = 3'b111;
    m_gnt = 1'b1;
    exp_g(0);
    step();
    exp_g(1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_gnt", 64'(gnt_s), 64'd0);
    chk("midrst_mreq", 64'(m_req), 64'd0);
    chk("midrst_unexp", 64'(unexp), 64'd0);
    step();
    rst_n = 1'b1;
    exp_g(0);
    step();
    req   = '0;
    m_gnt = 1'b0;
    exp_r(0, 64'h500, 1'b0);
    step();
    m_valid = 1'b1;
    m_rdata = 64'h501;
    @(negedge clk);
    chk("postrst_valid", 64'(vld_s), 64'd0);
    step();
    m_valid = 1'b0;
    @(negedge clk);
    chk("postrst_unexp", 64'(unexp), 64'd1);
    step();

    chk("gnt_queue_left", 64'(exp_gnt.size()), 64'd0);
    chk("rsp_queue_left", 64'(exp_rsp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
